// File: rtl/rv32m_pkg.sv
// Shared RV32M types and constants.
//   sign_type_t      : operand signedness decoded from the instruction
//   div_state_t      : sequential divider FSM states
//   DIV_OVF_DIVIDEND : most-negative dividend, used to detect signed overflow
package rv32m_pkg;

    typedef enum logic [1:0] {
        SIGNED          = 2'd0,
        UNSIGNED        = 2'd1,
        SIGNED_UNSIGNED = 2'd2
    } sign_type_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    localparam logic [31:0] DIV_OVF_DIVIDEND = 32'h8000_0000;

endpackage

// File: rtl/rv32m_div_step.sv
// One combinational restoring-division step.
//   rem_in  : partial remainder, always < divisor
//   q_in    : shifting dividend/quotient register
//   divisor : magnitude of the divisor
//   rem_out : partial remainder after this step
//   q_out   : q_in shifted left with the new quotient bit in bit 0
module rv32m_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] q_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic [WIDTH-1:0] q_out
);

    // The shifted remainder needs one extra bit: with a divisor >= 2^(WIDTH-1)
    // the partial remainder can reach 2^(WIDTH-1) and the shift would
    // otherwise drop its MSB. After subtraction it fits in WIDTH bits again.
    logic [WIDTH:0] trial;
    logic           ge;

    always_comb begin
        trial   = {rem_in, q_in[WIDTH-1]};
        ge      = (trial >= {1'b0, divisor});
        rem_out = ge ? (trial[WIDTH-1:0] - divisor) : trial[WIDTH-1:0];
        q_out   = {q_in[WIDTH-2:0], ge};
    end

endmodule

// File: rtl/rv32m_div_seq.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
//   CLK, RST  : clock, synchronous active-high reset
//   start     : request, accepted only in IDLE and only without flush
//   flush     : abandon any in-flight operation, no done pulse
//   div_type  : 0 = quotient, 1 = remainder
//   sign_type : SIGNED = signed operation, anything else = unsigned
//   dividend  : rs1, divisor : rs2 (sampled only at acceptance)
//   busy      : high in CALC and FIX
//   done      : one-cycle pulse, result valid
//   result    : quotient or remainder, held until the next result is written
// Handshake: the decoder raises start and holds it; the op is accepted on the
// first edge in IDLE with flush low. busy covers the iteration, done pulses
// once when result is updated. Starts seen outside IDLE are dropped.
module rv32m_div_seq
    import rv32m_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic             flush,
    input  logic             div_type,
    input  sign_type_t       sign_type,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] OVF_DIVIDEND = DIV_OVF_DIVIDEND[WIDTH-1:0];

    div_state_t       state_q, state_d;
    logic [CW-1:0]    counter_q, counter_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             div_type_q, div_type_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;

    logic             is_signed, a_neg, b_neg, div_zero, sgn_ovf;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH-1:0] step_rem, step_quo;

    rv32m_div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem_q),
        .q_in    (quo_q),
        .divisor (dvs_q),
        .rem_out (step_rem),
        .q_out   (step_quo)
    );

    always_comb begin
        is_signed = (sign_type == SIGNED);
        a_neg     = is_signed & dividend[WIDTH-1];
        b_neg     = is_signed & divisor[WIDTH-1];
        abs_a     = a_neg ? (~dividend + 1'b1) : dividend;
        abs_b     = b_neg ? (~divisor + 1'b1) : divisor;
        div_zero  = (divisor == '0);
        sgn_ovf   = is_signed && (dividend == OVF_DIVIDEND) && (divisor == '1);
    end

    always_comb begin
        state_d    = state_q;
        counter_d  = counter_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        dvs_d      = dvs_q;
        result_d   = result_q;
        div_type_d = div_type_q;
        neg_quo_d  = neg_quo_q;
        neg_rem_d  = neg_rem_q;

        case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    div_type_d = div_type;
                    neg_quo_d  = a_neg ^ b_neg;
                    neg_rem_d  = a_neg;
                    rem_d      = '0;
                    quo_d      = abs_a;
                    dvs_d      = abs_b;
                    if (div_zero) begin
                        // Remainder is the raw rs1 value regardless of signedness.
                        result_d = div_type ? dividend : '1;
                        state_d  = DONE;
                    end else if (sgn_ovf) begin
                        result_d = div_type ? '0 : OVF_DIVIDEND;
                        state_d  = DONE;
                    end else begin
                        counter_d = CW'(WIDTH - 1);
                        state_d   = CALC;
                    end
                end
            end
            CALC: begin
                rem_d = step_rem;
                quo_d = step_quo;
                if (counter_q == '0) begin
                    state_d = FIX;
                end else begin
                    counter_d = counter_q - 1'b1;
                end
            end
            FIX: begin
                if (div_type_q) begin
                    result_d = neg_rem_q ? (~rem_q + 1'b1) : rem_q;
                end else begin
                    result_d = neg_quo_q ? (~quo_q + 1'b1) : quo_q;
                end
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A flush abandons the op from any state and must not touch result.
        if (flush) begin
            state_d  = IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            counter_q  <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            dvs_q      <= '0;
            result_q   <= '0;
            div_type_q <= 1'b0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            counter_q  <= counter_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            dvs_q      <= dvs_d;
            result_q   <= result_d;
            div_type_q <= div_type_d;
            neg_quo_q  <= neg_quo_d;
            neg_rem_q  <= neg_rem_d;
        end
    end

    assign busy   = (state_q == CALC) || (state_q == FIX);
    assign done   = (state_q == DONE);
    assign result = result_q;

endmodule

// File: tb/tb_rv32m_div_seq.sv
module tb_rv32m_div_seq;
    import rv32m_pkg::*;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic        div_type = 1'b0;
    sign_type_t  sign_type = UNSIGNED;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int tests_run = 0;
    int tests_failed = 0;
    logic [31:0] exp_q[$];

    always #5 CLK = ~CLK;

    rv32m_div_seq #(.WIDTH(32)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .start     (start),
        .flush     (flush),
        .div_type  (div_type),
        .sign_type (sign_type),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .result    (result)
    );

    // Reference: RISC-V M semantics built from SV arithmetic.
    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic dt, input sign_type_t st);
        logic [31:0] q, r;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (st == SIGNED && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else if (st == SIGNED) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return dt ? r : q;
    endfunction

    function automatic int exp_latency(input logic [31:0] a, input logic [31:0] b,
                                       input sign_type_t st);
        if (b == 32'd0) return 1;
        if (st == SIGNED && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic dt,
                          input sign_type_t st, input string name);
        int cyc;
        int lat;
        logic [31:0] exp;
        @(negedge CLK);
        dividend  = a;
        divisor   = b;
        div_type  = dt;
        sign_type = st;
        start     = 1'b1;
        exp_q.push_back(model(a, b, dt, st));
        lat = exp_latency(a, b, st);
        @(posedge CLK);
        #1;
        start     = 1'b0;
        dividend  = $urandom;
        divisor   = $urandom;
        div_type  = ~dt;
        sign_type = sign_type_t'($urandom_range(0, 2));
        cyc = 1;
        while (!done && cyc < 100) begin
            @(posedge CLK);
            #1;
            cyc++;
        end
        exp = exp_q.pop_front();
        tests_run++;
        if (done !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s timeout: done not seen in %0d cycles", name, cyc);
        end else begin
            if (result !== exp) begin
                tests_failed++;
                $display("FAIL %s result: got %h expected %h", name, result, exp);
            end
            tests_run++;
            if (cyc !== lat) begin
                tests_failed++;
                $display("FAIL %s latency: got %0d expected %0d", name, cyc, lat);
            end
            @(posedge CLK);
            #1;
            tests_run++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL %s pulse: done=%b busy=%b expected 0 0", name, done, busy);
            end
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset: busy=%b done=%b result=%h expected 0 0 0", busy, done, result);
        end
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic test_unsigned();
        run_op(32'd100, 32'd7, 1'b0, UNSIGNED, "divu_100_7");
        run_op(32'd100, 32'd7, 1'b1, UNSIGNED, "remu_100_7");
        run_op(32'hFFFF_FFFF, 32'h8000_0001, 1'b0, UNSIGNED, "divu_big");
        run_op(32'hFFFF_FFFF, 32'h8000_0001, 1'b1, SIGNED_UNSIGNED, "remu_big");
    endtask

    task automatic test_signed();
        run_op(-32'sd7, 32'd2, 1'b0, SIGNED, "div_m7_2");
        run_op(-32'sd7, 32'd2, 1'b1, SIGNED, "rem_m7_2");
        run_op(32'd7, -32'sd2, 1'b1, SIGNED, "rem_7_m2");
        run_op(-32'sd100, -32'sd9, 1'b0, SIGNED, "div_m100_m9");
    endtask

    task automatic test_div_zero();
        run_op(32'h1234, 32'd0, 1'b0, SIGNED, "div_zero_q");
        run_op(32'h1234, 32'd0, 1'b1, UNSIGNED, "div_zero_r");
        run_op(32'hF000_0001, 32'd0, 1'b1, SIGNED, "div_zero_rneg");
    endtask

    task automatic test_overflow();
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, SIGNED, "ovf_div");
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, SIGNED, "ovf_rem");
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, UNSIGNED, "ovf_divu");
    endtask

    task automatic test_flush();
        run_op(32'd100, 32'd7, 1'b0, UNSIGNED, "flush_pre");
        @(negedge CLK);
        dividend = 32'd1000;
        divisor  = 32'd3;
        div_type = 1'b0;
        sign_type = UNSIGNED;
        start = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0;
        repeat (9) @(posedge CLK);
        @(negedge CLK);
        flush = 1'b1;
        @(posedge CLK);
        #1;
        flush = 1'b0;
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd14) begin
            tests_failed++;
            $display("FAIL flush_kill: busy=%b done=%b result=%h expected 0 0 0000000e",
                     busy, done, result);
        end
        run_op(32'd1000, 32'd3, 1'b1, UNSIGNED, "flush_after");
        // flush and start together: nothing may be accepted
        @(negedge CLK);
        dividend = 32'd50;
        divisor  = 32'd5;
        div_type = 1'b0;
        start = 1'b1;
        flush = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0;
        flush = 1'b0;
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd1) begin
            tests_failed++;
            $display("FAIL flush_start: busy=%b done=%b result=%h expected 0 0 00000001",
                     busy, done, result);
        end
    endtask

    task automatic test_rst_mid();
        run_op(32'd7, -32'sd2, 1'b1, SIGNED, "rst_pre");
        @(negedge CLK);
        dividend = 32'd999;
        divisor  = 32'd4;
        div_type = 1'b0;
        sign_type = UNSIGNED;
        start = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0;
        repeat (5) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
            tests_failed++;
            $display("FAIL rst_mid: busy=%b done=%b result=%h expected 0 0 0", busy, done, result);
        end
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic test_ignore_start();
        int cyc;
        int n_done;
        logic [31:0] exp;
        n_done = 0;
        @(negedge CLK);
        dividend = 32'd100;
        divisor  = 32'd7;
        div_type = 1'b0;
        sign_type = UNSIGNED;
        start = 1'b1;
        exp_q.push_back(model(32'd100, 32'd7, 1'b0, UNSIGNED));
        @(posedge CLK);
        #1;
        start = 1'b0;
        cyc = 1;
        while (cyc < 60) begin
            start    = (cyc == 5 || cyc == 20 || cyc == 34);
            dividend = $urandom;
            divisor  = $urandom_range(1, 50);
            @(posedge CLK);
            #1;
            cyc++;
            if (done === 1'b1) begin
                n_done++;
                if (exp_q.size() > 0) begin
                    exp = exp_q.pop_front();
                    tests_run++;
                    if (result !== exp) begin
                        tests_failed++;
                        $display("FAIL ignore_start result: got %h expected %h", result, exp);
                    end
                end
            end
        end
        start = 1'b0;
        tests_run++;
        if (n_done !== 1) begin
            tests_failed++;
            $display("FAIL ignore_start count: got %0d done pulses expected 1", n_done);
        end
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        run_op(32'd81, 32'd9, 1'b0, UNSIGNED, "b2b_1");
        run_op(32'd81, 32'd0, 1'b1, UNSIGNED, "b2b_2");
        run_op(32'd82, 32'd9, 1'b1, SIGNED, "b2b_3");
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        for (int i = 0; i < 8; i++) begin
            a = $urandom;
            b = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 300)) : $urandom;
            if ($urandom_range(0, 1) == 1) b = -b;
            run_op(a, b, 1'($urandom_range(0, 1)), sign_type_t'($urandom_range(0, 2)), "random");
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_overflow();
        test_flush();
        test_rst_mid();
        test_ignore_start();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
